// File: rtl/store_pkg.sv
// Shared definitions for the store sequencer: store-size encodings and FSM states.
package store_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CAPT,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } st_state_t;

endpackage

// File: rtl/store_sequencer_if.sv
// Request handshake and data-memory bus of the store sequencer.
interface store_sequencer_if;
  logic        start;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [31:0] mdr_out;

  modport master (
    output start, req_addr, req_data, req_size, mem_rdata,
    input  busy, done, err, mem_addr, mem_wr, mem_wdata, mdr_out
  );

  modport slave (
    input  start, req_addr, req_data, req_size, mem_rdata,
    output busy, done, err, mem_addr, mem_wr, mem_wdata, mdr_out
  );
endinterface

// File: rtl/store_merge.sv
// Merges the store data into the old memory word according to the store size.
module store_merge
  import store_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [31:0] mdr,
  input  logic [31:0] data,
  output logic [31:0] merged
);

  always_comb begin
    merged = mdr;
    case (size)
      SZ_BYTE: merged = {mdr[31:8], data[7:0]};
      SZ_HALF: merged = {mdr[31:16], data[15:0]};
      SZ_WORD: merged = data;
      default: merged = mdr;
    endcase
  end

endmodule

// File: rtl/store_sequencer.sv
// Multicycle store engine: direct word writes, read-modify-write for byte/halfword.
module store_sequencer
  import store_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  store_sequencer_if.slave bus
);

  localparam int unsigned     CW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0]   CNT_LOAD = CW'(MEM_LAT - 1);

  st_state_t     state;
  st_state_t     nxt;
  logic [CW-1:0] cnt;
  logic [31:0]   addr_q;
  logic [31:0]   data_q;
  logic [1:0]    size_q;
  logic [31:0]   mdr_q;
  logic [31:0]   merged;
  logic          busy_q;
  logic          wr_q;
  logic          done_q;
  logic          err_q;

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:
        if (bus.start) begin
          case (bus.req_size)
            SZ_WORD:          nxt = ST_WRITE;
            SZ_BYTE, SZ_HALF: nxt = ST_READ;
            default:          nxt = ST_ERR;
          endcase
        end
      ST_READ:  if (cnt == '0) nxt = ST_CAPT;
      ST_CAPT:  nxt = ST_WRITE;
      ST_WRITE: nxt = ST_DONE;
      default:  nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      addr_q <= '0;
      data_q <= '0;
      size_q <= '0;
      mdr_q  <= '0;
      busy_q <= 1'b0;
      wr_q   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= nxt;
      busy_q <= (nxt != ST_IDLE);
      wr_q   <= (nxt == ST_WRITE);
      done_q <= (nxt == ST_DONE) || (nxt == ST_ERR);
      err_q  <= (nxt == ST_ERR);
      if (state == ST_IDLE && bus.start) begin
        addr_q <= bus.req_addr;
        data_q <= bus.req_data;
        size_q <= bus.req_size;
        cnt    <= CNT_LOAD;
      end
      if (state == ST_READ && cnt != '0) cnt <= cnt - CW'(1);
      if (state == ST_CAPT) mdr_q <= bus.mem_rdata;
    end
  end

  store_merge u_merge (
    .size   (size_q),
    .mdr    (mdr_q),
    .data   (data_q),
    .merged (merged)
  );

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.mem_wr    = wr_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = merged;
  assign bus.mdr_out   = mdr_q;

endmodule

// File: tb/tb_store_sequencer.sv
// Scoreboard bench for store_sequencer: two instances (MEM_LAT=1 and MEM_LAT=3).
module tb_store_sequencer;
  import store_pkg::*;

  typedef struct {
    bit          is_done;
    int unsigned cyc;
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
  } exp_t;

  typedef struct {
    int unsigned u;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] mdr;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  int unsigned cyc = 0;
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  logic        start     [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_data  [2];
  logic [1:0]  req_size  [2];
  logic        busy      [2];
  logic        done      [2];
  logic        err       [2];
  logic        mem_wr    [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  logic [31:0] mdr_out   [2];
  logic [31:0] pipe      [2][3];

  exp_t q0[$];
  exp_t q1[$];

  store_sequencer_if bus[2] ();

  for (genvar g = 0; g < 2; g++) begin : u
    assign bus[g].start     = start[g];
    assign bus[g].req_addr  = req_addr[g];
    assign bus[g].req_data  = req_data[g];
    assign bus[g].req_size  = req_size[g];
    assign bus[g].mem_rdata = mem_rdata[g];
    assign busy[g]          = bus[g].busy;
    assign done[g]          = bus[g].done;
    assign err[g]           = bus[g].err;
    assign mem_wr[g]        = bus[g].mem_wr;
    assign mem_addr[g]      = bus[g].mem_addr;
    assign mem_wdata[g]     = bus[g].mem_wdata;
    assign mdr_out[g]       = bus[g].mdr_out;

    store_sequencer #(.MEM_LAT((g == 0) ? 1 : 3)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus[g])
    );
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'h1122_3344 ^ {4{a[7:0]}};
  endfunction

  function automatic int unsigned lat(input int unsigned uu);
    return (uu == 0) ? 1 : 3;
  endfunction

  // Read port with latency: garbage is fed in whenever the sequencer is not busy.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      pipe[g][0] <= busy[g] ? rom(mem_addr[g]) : 32'hBAD0_BAD0;
      pipe[g][1] <= pipe[g][0];
      pipe[g][2] <= pipe[g][1];
    end
  end
  assign mem_rdata[0] = pipe[0][0];
  assign mem_rdata[1] = pipe[1][2];

  task automatic push(input int unsigned uu, input exp_t e);
    if (uu == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic check_evt(input int unsigned uu, input bit is_done);
    exp_t        e;
    logic [31:0] a_got;
    logic [31:0] d_got;
    logic        e_got;
    int unsigned qs;
    a_got = is_done ? 32'h0 : mem_addr[uu];
    d_got = is_done ? mdr_out[uu] : mem_wdata[uu];
    e_got = is_done ? err[uu] : 1'b0;
    qs    = (uu == 0) ? q0.size() : q1.size();
    n_vec++;
    if (qs == 0) begin
      n_bad++;
      $display("FAIL unexpected_event u=%0d done=%0b cyc=%0d: got addr=%h data=%h err=%b, want no event",
               uu, is_done, cyc, a_got, d_got, e_got);
      return;
    end
    if (uu == 0) e = q0.pop_front();
    else e = q1.pop_front();
    if (e.is_done !== is_done || e.cyc != cyc || e.addr !== a_got || e.data !== d_got || e.err !== e_got) begin
      n_bad++;
      $display("FAIL event u=%0d: got done=%0b cyc=%0d addr=%h data=%h err=%b, want done=%0b cyc=%0d addr=%h data=%h err=%b",
               uu, is_done, cyc, a_got, d_got, e_got, e.is_done, e.cyc, e.addr, e.data, e.err);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      for (int g = 0; g < 2; g++) begin
        if (mem_wr[g]) check_evt(g, 1'b0);
        if (done[g]) check_evt(g, 1'b1);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input int unsigned uu, input string tag);
    chk($sformatf("%s_busy%0d", tag, uu), {31'b0, busy[uu]}, 32'h0);
    chk($sformatf("%s_done%0d", tag, uu), {31'b0, done[uu]}, 32'h0);
    chk($sformatf("%s_err%0d", tag, uu), {31'b0, err[uu]}, 32'h0);
    chk($sformatf("%s_wr%0d", tag, uu), {31'b0, mem_wr[uu]}, 32'h0);
    chk($sformatf("%s_addr%0d", tag, uu), mem_addr[uu], 32'h0);
    chk($sformatf("%s_wdata%0d", tag, uu), mem_wdata[uu], 32'h0);
    chk($sformatf("%s_mdr%0d", tag, uu), mdr_out[uu], 32'h0);
  endtask

  task automatic issue(input int unsigned uu, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz, input logic [31:0] wd, input logic [31:0] md,
                       input bit track, output int unsigned c0);
    @(negedge clk);
    c0 = cyc;
    start[uu] = 1'b1;
    req_addr[uu] = a;
    req_data[uu] = d;
    req_size[uu] = sz;
    if (track) begin
      if (sz == SZ_WORD) begin
        push(uu, '{1'b0, c0 + 1, a, wd, 1'b0});
        push(uu, '{1'b1, c0 + 2, 32'h0, md, 1'b0});
      end else if (sz == 2'b11) begin
        push(uu, '{1'b1, c0 + 1, 32'h0, md, 1'b1});
      end else begin
        push(uu, '{1'b0, c0 + lat(uu) + 2, a, wd, 1'b0});
        push(uu, '{1'b1, c0 + lat(uu) + 3, 32'h0, md, 1'b0});
      end
    end
    @(negedge clk);
    start[uu] = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (q0.size() == 0 && q1.size() == 0 && !busy[0] && !busy[1]) ok = 1'b1;
    end
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL drain_timeout: got pending q0=%0d q1=%0d busy=%b%b, want idle", q0.size(), q1.size(), busy[0], busy[1]);
    end
  endtask

  vec_t vecs[7] = '{
    '{0, 32'h0000_0040, 32'hDEAD_BEEF, 2'b10, 32'hDEAD_BEEF, 32'h0000_0000},
    '{0, 32'h0000_0100, 32'hAABB_CCDD, 2'b00, 32'h1122_33DD, 32'h1122_3344},
    '{1, 32'h0000_0200, 32'h0000_BEEF, 2'b01, 32'h1122_BEEF, 32'h1122_3344},
    '{0, 32'h0000_0080, 32'h1234_5678, 2'b11, 32'h0000_0000, 32'h1122_3344},
    '{0, 32'h0000_01C4, 32'hCAFE_F00D, 2'b01, 32'hD5E6_F00D, 32'hD5E6_F780},
    '{1, 32'h0000_01C4, 32'h0102_0304, 2'b00, 32'hD5E6_F704, 32'hD5E6_F780},
    '{1, 32'h0000_01C4, 32'hA5A5_A5A5, 2'b10, 32'hA5A5_A5A5, 32'hD5E6_F780}
  };

  initial begin
    int unsigned c0;
    for (int g = 0; g < 2; g++) begin
      start[g] = 1'b0;
      req_addr[g] = 32'h0;
      req_data[g] = 32'h0;
      req_size[g] = 2'b00;
    end
    reset_n = 1'b0;
    #1;
    chk_zero(0, "reset");
    chk_zero(1, "reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      issue(vecs[i].u, vecs[i].addr, vecs[i].data, vecs[i].size, vecs[i].wdata, vecs[i].mdr, 1'b1, c0);
      drain();
    end

    // start held high: a second word store is accepted on the first IDLE cycle
    @(negedge clk);
    c0 = cyc;
    start[0] = 1'b1;
    req_addr[0] = 32'h0000_0044;
    req_data[0] = 32'h1357_9BDF;
    req_size[0] = SZ_WORD;
    push(0, '{1'b0, c0 + 1, 32'h0000_0044, 32'h1357_9BDF, 1'b0});
    push(0, '{1'b1, c0 + 2, 32'h0, 32'hD5E6_F780, 1'b0});
    push(0, '{1'b0, c0 + 4, 32'h0000_0044, 32'h1357_9BDF, 1'b0});
    push(0, '{1'b1, c0 + 5, 32'h0, 32'hD5E6_F780, 1'b0});
    repeat (4) @(negedge clk);
    start[0] = 1'b0;
    drain();

    // start pulsed during READ must be dropped
    issue(1, 32'h0000_0100, 32'h0000_0077, SZ_BYTE, 32'h1122_3377, 32'h1122_3344, 1'b1, c0);
    chk("busy_in_read", {31'b0, busy[1]}, 32'h1);
    start[1] = 1'b1;
    req_addr[1] = 32'h0000_0040;
    req_data[1] = 32'hFFFF_FFFF;
    req_size[1] = SZ_WORD;
    @(negedge clk);
    start[1] = 1'b0;
    drain();

    // asynchronous reset in the middle of an sh write
    issue(1, 32'h0000_0300, 32'h0000_ABCD, SZ_HALF, 32'h0, 32'h0, 1'b0, c0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    chk("wr_before_reset", {31'b0, mem_wr[1]}, 32'h1);
    reset_n = 1'b0;
    #1;
    chk_zero(1, "midreset");
    chk_zero(0, "midreset");
    @(negedge clk);
    reset_n = 1'b1;
    issue(1, 32'h0000_0100, 32'hAABB_CCDD, SZ_BYTE, 32'h1122_33DD, 32'h1122_3344, 1'b1, c0);
    drain();
    issue(0, 32'h0000_0048, 32'h0BAD_F00D, SZ_WORD, 32'h0BAD_F00D, 32'h0, 1'b1, c0);
    drain();

    chk("q0_left", q0.size(), 32'h0);
    chk("q1_left", q1.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
